// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the single-clock register FIFO family.
package fifo_pkg;

   localparam int unsigned ERR_STICKY_FULL = 0;
   localparam int unsigned ERR_STICKY      = 1;
   localparam int unsigned ERR_DYNAMIC     = 2;

   // rst_mode bit0 set means reset leaves the storage array untouched.
   localparam int unsigned RST_KEEP_MEM_BIT = 0;
   localparam int unsigned RST_ASYNC_BIT    = 1;

   function automatic int unsigned cnt_width(input int unsigned d);
      return $clog2(d + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/fifo_s1_sf_ctl.sv
// FIFO control: pointers, occupancy count, status flag decode and error tracking.
module fifo_s1_sf_ctl
   import fifo_pkg::*;
#(
   parameter int unsigned depth    = 4,
   parameter int unsigned ae_level = 1,
   parameter int unsigned af_level = 1,
   parameter int unsigned err_mode = 0,
   localparam int unsigned AW      = ptr_width(depth),
   localparam int unsigned CW      = cnt_width(depth)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_req_n_i,
   input  logic          pop_req_n_i,
   input  logic          diag_n_i,
   output logic          we_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [AW-1:0] rd_addr_o,
   output logic          empty_o,
   output logic          almost_empty_o,
   output logic          half_full_o,
   output logic          almost_full_o,
   output logic          full_o,
   output logic          error_o
);

   localparam logic [AW-1:0] PtrLast = AW'(depth - 1);
   localparam bit            Sticky  = (err_mode == ERR_STICKY_FULL) || (err_mode == ERR_STICKY);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          error_q, error_d;
   logic          push_ok, pop_ok, err_ev, diag_clr;

   // Flags decode straight from the registered count.
   assign empty_o        = (count_q == '0);
   assign almost_empty_o = (count_q <= CW'(ae_level));
   assign half_full_o    = (count_q >= CW'((depth + 1) / 2));
   assign almost_full_o  = (count_q >= CW'(depth - af_level));
   assign full_o         = (count_q == CW'(depth));
   assign error_o        = error_q;
   assign wr_addr_o      = wr_ptr_q;
   assign rd_addr_o      = rd_ptr_q;

   always_comb begin
      push_ok  = 1'b0;
      pop_ok   = 1'b0;
      err_ev   = 1'b0;
      diag_clr = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      error_d  = error_q;
      we_o     = 1'b0;

      // A pop on a full FIFO frees the slot the simultaneous push needs.
      push_ok  = ~push_req_n_i & (~full_o | ~pop_req_n_i);
      pop_ok   = ~pop_req_n_i & ~empty_o;
      err_ev   = (~push_req_n_i & full_o & pop_req_n_i) | (~pop_req_n_i & empty_o);
      diag_clr = (err_mode == ERR_STICKY_FULL) && !diag_n_i;

      if (diag_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      error_d = Sticky ? (error_q | err_ev) : err_ev;
      we_o    = push_ok & ~diag_clr & ~reset;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: rtl/fifo_s1_sf.sv
// Single-clock show-ahead FIFO: register storage array plus read mux around the control block.
module fifo_s1_sf
   import fifo_pkg::*;
#(
   parameter int unsigned width    = 8,
   parameter int unsigned depth    = 4,
   parameter int unsigned ae_level = 1,
   parameter int unsigned af_level = 1,
   parameter int unsigned err_mode = 0,
   parameter int unsigned rst_mode = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_req_n,
   input  logic             pop_req_n,
   input  logic             diag_n,
   input  logic [width-1:0] data_in,
   output logic             empty,
   output logic             almost_empty,
   output logic             half_full,
   output logic             almost_full,
   output logic             full,
   output logic             error,
   output logic [width-1:0] data_out
);

   localparam int unsigned AW     = ptr_width(depth);
   localparam bit          ClrMem = ((rst_mode >> RST_KEEP_MEM_BIT) & 1) == 0;

   logic             we;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic [width-1:0] mem_q [depth];

   fifo_s1_sf_ctl #(
      .depth    (depth),
      .ae_level (ae_level),
      .af_level (af_level),
      .err_mode (err_mode)
   ) u_ctl (
      .clock          (clock),
      .reset          (reset),
      .push_req_n_i   (push_req_n),
      .pop_req_n_i    (pop_req_n),
      .diag_n_i       (diag_n),
      .we_o           (we),
      .wr_addr_o      (wr_addr),
      .rd_addr_o      (rd_addr),
      .empty_o        (empty),
      .almost_empty_o (almost_empty),
      .half_full_o    (half_full),
      .almost_full_o  (almost_full),
      .full_o         (full),
      .error_o        (error)
   );

   generate
      if (ClrMem) begin : g_mem_clr
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
            end else if (we) begin
               mem_q[wr_addr] <= data_in;
            end
         end
      end else begin : g_mem_keep
         always_ff @(posedge clock) begin
            if (we) mem_q[wr_addr] <= data_in;
         end
      end
   endgenerate

   assign data_out = mem_q[rd_addr];

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Directed bench: dynamic-error FIFO plus a sticky-error/diag instance sharing the same stimulus.
module tb_fifo_s1_sf;

   logic        clock = 1'b0;
   logic        reset, push_req_n, pop_req_n, diag_n, diag0_n;
   logic [31:0] data_in;
   logic        empty, almost_empty, half_full, almost_full, full, error;
   logic [31:0] data_out;
   logic        empty0, almost_empty0, half_full0, almost_full0, full0, error0;
   logic [31:0] data_out0;
   int          npass = 0;
   int          ntot  = 0;

   always #5 clock = ~clock;

   fifo_s1_sf #(.width(32), .depth(4), .ae_level(1), .af_level(1),
                .err_mode(2), .rst_mode(3)) dut (
      .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
      .diag_n(diag_n), .data_in(data_in), .empty(empty), .almost_empty(almost_empty),
      .half_full(half_full), .almost_full(almost_full), .full(full), .error(error),
      .data_out(data_out));

   fifo_s1_sf #(.width(32), .depth(4), .ae_level(1), .af_level(1),
                .err_mode(0), .rst_mode(0)) dut0 (
      .clock(clock), .reset(reset), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
      .diag_n(diag0_n), .data_in(data_in), .empty(empty0), .almost_empty(almost_empty0),
      .half_full(half_full0), .almost_full(almost_full0), .full(full0), .error(error0),
      .data_out(data_out0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // flags packed as {empty, almost_empty, half_full, almost_full, full, error}
   task automatic chk_flags(input string tag, input logic [5:0] exp);
      chk(tag, 32'({empty, almost_empty, half_full, almost_full, full, error}), 32'(exp));
   endtask

   task automatic step(input logic push, input logic pop, input logic [31:0] d);
      push_req_n = ~push;
      pop_req_n  = ~pop;
      data_in    = d;
      @(posedge clock);
      #1;
      push_req_n = 1'b1;
      pop_req_n  = 1'b1;
   endtask

   initial begin
      reset = 1'b1; push_req_n = 1'b1; pop_req_n = 1'b1;
      diag_n = 1'b1; diag0_n = 1'b1; data_in = '0;
      step(0, 0, 0);
      step(0, 0, 0);
      reset = 1'b0;
      chk_flags("reset_flags", 6'b110000);
      chk("reset_dout0", data_out0, 32'h0);
      step(0, 0, 0);
      chk_flags("idle_flags", 6'b110000);

      // Fill
      step(1, 0, 32'h11); chk_flags("cnt1", 6'b010000); chk("cnt1_dout", data_out, 32'h11);
      step(1, 0, 32'h22); chk_flags("cnt2", 6'b001000);
      step(1, 0, 32'h33); chk_flags("cnt3", 6'b001100);
      step(1, 0, 32'h44); chk_flags("cnt4", 6'b001110);

      // Overflow
      step(1, 0, 32'h55); chk_flags("ovf_err", 6'b001111); chk("ovf_head", data_out, 32'h11);
      chk("ovf_sticky", 32'(error0), 32'h1);
      step(0, 0, 0);      chk_flags("ovf_err_clr", 6'b001110);
      chk("ovf_sticky_hold", 32'(error0), 32'h1);

      // Push+pop while full
      step(1, 1, 32'h66); chk_flags("full_pp", 6'b001110); chk("full_pp_head", data_out, 32'h22);

      // Drain
      chk("drain0", data_out, 32'h22); step(0, 1, 0);
      chk("drain1", data_out, 32'h33); step(0, 1, 0);
      chk("drain2", data_out, 32'h44); step(0, 1, 0);
      chk("drain3", data_out, 32'h66); step(0, 1, 0);
      chk_flags("drained", 6'b110000);

      // Underflow
      step(0, 1, 0); chk_flags("udf_err", 6'b110001);
      step(0, 0, 0); chk_flags("udf_clr", 6'b110000);
      chk("udf_sticky", 32'(error0), 32'h1);

      // Show-ahead
      step(1, 0, 32'hDEADBEEF);
      chk_flags("sa_flags", 6'b010000); chk("sa_dout", data_out, 32'hDEADBEEF);
      step(0, 1, 0); chk_flags("sa_pop", 6'b110000);

      // Push+pop while empty
      step(1, 1, 32'h77);
      chk_flags("empty_pp", 6'b010001); chk("empty_pp_dout", data_out, 32'h77);

      // Wraparound with one word resident
      step(1, 1, 32'hA0);
      chk("wrap_init", data_out, 32'hA0); chk("wrap_init_err", 32'(error), 32'h0);
      for (int i = 1; i <= 10; i++) begin
         step(1, 1, 32'hA0 + 32'(i));
         chk($sformatf("wrap%0d", i), data_out, 32'hA0 + 32'(i));
      end
      chk_flags("wrap_flags", 6'b010000);
      step(1, 0, 32'hB1);
      step(1, 0, 32'hB2);
      chk_flags("cnt3_pre_rst", 6'b001100);
      chk("cnt3_head", data_out, 32'hAA);

      // Reset with a concurrent push is discarded
      reset = 1'b1;
      step(1, 0, 32'hCC);
      reset = 1'b0;
      chk_flags("mid_rst", 6'b110000);
      chk("mid_rst_sticky", 32'(error0), 32'h0);
      chk("mid_rst_dout0", data_out0, 32'h0);

      // Diagnostic clear on the err_mode 0 instance only
      step(1, 0, 32'hE1);
      step(1, 0, 32'hE2);
      diag0_n = 1'b0;
      step(0, 0, 0);
      diag0_n = 1'b1;
      chk("diag_empty0", 32'(empty0), 32'h1);
      chk("diag_other", 32'(empty), 32'h0);
      step(1, 0, 32'hF0);
      chk("diag_refill", data_out0, 32'hF0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/fifo_s1_sf.md
Name: fifo_s1_sf

Overview:
- Single-clock synchronous FIFO with a register-based store, parameterized depth and width.
- Active-low push/pop requests and show-ahead (fall-through) read data.
- Provides empty, almost-empty, half-full, almost-full, full and error status.
- Used as the result/data queue in VRF read pipes (typical instance: depth 4, width 32, ae_level 1, af_level 1, err_mode 2, rst_mode 3).

Parameters:
- width, 8, data word width in bits (1..256).
- depth, 4, number of words stored (2..256); need not be a power of two.
- ae_level, 1, almost_empty threshold (1..depth-1).
- af_level, 1, almost_full threshold, counted in words below full (1..depth-1).
- err_mode, 0, error reporting: 0 or 1 = sticky; 2 = dynamic (one cycle per offending request).
- rst_mode, 0, bit0 = 0: reset clears storage; bit0 = 1: reset clears only pointers and flags. Bit1 is ignored; reset is always synchronous.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- push_req_n  in  1  active-low push request
- pop_req_n  in  1  active-low pop request
- diag_n  in  1  active-low diagnostic pointer clear; tie to 1 in normal use
- data_in  in  width  push data
- empty  out  1  count == 0
- almost_empty  out  1  count <= ae_level
- half_full  out  1  count >= (depth+1)/2
- almost_full  out  1  count >= depth - af_level
- full  out  1  count == depth
- error  out  1  overflow/underflow indicator
- data_out  out  width  word at the read pointer (show-ahead)

Behaviour:
- One clock (clock); reset is synchronous and active-high. It is sampled on the rising edge and has priority over all other inputs.
- State:
  - rd_ptr and wr_ptr, range 0..depth-1; each wraps from depth-1 to 0.
  - count, width clog2(depth+1).
  - storage array depth x width.
  - error register.
- All flags decode combinationally from the registered count. They therefore change in the cycle after the request edge.
- Reset values:
  - count = 0, pointers = 0, error = 0.
  - empty = 1, almost_empty = 1, half_full = 0, almost_full = 0, full = 0.
  - data_out = 0 if rst_mode bit0 = 0; otherwise storage and data_out are unspecified after reset.
- Push: when push_req_n = 0 and the FIFO is not full, mem[wr_ptr] <= data_in, wr_ptr advances, count increments.
- Pop: when pop_req_n = 0 and the FIFO is not empty, rd_ptr advances and count decrements.
- data_out = mem[rd_ptr] combinationally. It is valid whenever empty = 0, so the head word is visible before the pop.
- Simultaneous push and pop:
  - Not empty and not full: both execute, count unchanged.
  - Full: both execute (pop frees the slot), count stays depth, no error.
  - Empty: push executes, pop is an underflow; count becomes 1, error event.
- Overflow: push while full without pop. Data is dropped, state unchanged, error event.
- Underflow: pop while empty. State unchanged, error event.
- error:
  - err_mode 0/1: set on any error event and held until reset.
  - err_mode 2: registered. It is 1 in the cycle after an error event and 0 otherwise.
- diag_n = 0 (err_mode 0 only): pointers and count clear to 0 on the next edge; storage is untouched. Ignored for err_mode 1/2.
- Reset asserted mid-operation: everything returns to reset values on that edge; a push or pop in the same cycle is discarded.
- Non-power-of-two depth: pointer wrap is an explicit compare against depth-1, not a bit truncation.

Decomposition:
- Shared package fifo_pkg:
  - err_mode constants: ERR_STICKY_FULL = 0, ERR_STICKY = 1, ERR_DYNAMIC = 2.
  - rst_mode bit definitions.
  - clog2-based count-width helper function.
- One natural sub-module, fifo_s1_sf_ctl. It holds pointers, count, flag decode and error logic, and outputs the write enable plus read/write addresses.
- The top module owns the register storage array and the data_out mux.

Test Plan:
All scenarios use depth=4, width=32, ae=1, af=1, err_mode=2, rst_mode=3 unless noted.
- Reset then idle: hold reset 2 cycles, then release → empty=1, almost_empty=1, full=0, almost_full=0, half_full=0, error=0.
- Fill and drain: push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - After each push count = 1..4. almost_empty drops at count 2, half_full rises at 2, almost_full rises at 3, full rises at 4.
  - Pop 4 times → data_out shows 0x11,0x22,0x33,0x44 before each pop, then empty=1.
- Show-ahead: push 0xDEADBEEF into an empty FIFO → next cycle empty=0 and data_out=0xDEADBEEF with no pop issued.
- Overflow/underflow:
  - push 0x55 while full with no pop → error=1 for exactly one cycle, contents unchanged.
  - pop while empty → error=1 for one cycle.
  - With err_mode=0 the same stimulus → error stays 1 until reset.
- Simultaneous push and pop:
  - Full: push 0x66 with pop → count stays 4, head advances, 0x66 becomes the tail, error=0.
  - Empty: push 0x77 with pop → count=1, data_out=0x77, error pulse.
- Wraparound and reset: 10 push/pop pairs with distinct data → FIFO order preserved across pointer wrap. Assert reset while count=3 → empty=1 the next cycle.
